// File: rtl/eighty_twos_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eighty_twos_resp_pkg
// Description : Shared types and constants for the eighty_twos bus responder:
//               transaction state encoding, command-byte write bit and the
//               default storage geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package eighty_twos_resp_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_AW    = 4;

  // Bit of the command byte that selects write (1) or read (0)
  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RTURN = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

endpackage : eighty_twos_resp_pkg
`default_nettype wire

// File: rtl/eighty_twos_resp_regfile.sv
`default_nettype none
// ============================================================================
// Module      : eighty_twos_resp_regfile
// Description : DEPTH x 8-bit storage with one synchronous write port, one
//               asynchronous read port and an asynchronous clear of every
//               location on nrst.
// Revision    : 1.0 - initial release
// ============================================================================
module eighty_twos_resp_regfile #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    // One byte cell: cleared by reset, loaded when addressed by a write
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_mem[gi] <= 8'h00;
      end else if (i_we && (i_waddr == AW'(gi))) begin
        r_mem[gi] <= i_wdata;
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : eighty_twos_resp_regfile
`default_nettype wire

// File: rtl/eighty_twos_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : eighty_twos_bus_responder
// Description : Byte-serial bus responder. An initiator sends a command byte
//               (bit7 = write), an address byte, then either a data byte
//               (write) or, after a one-cycle bus turnaround, receives a data
//               byte and acknowledges it (read). Out-of-range addresses set a
//               sticky err flag that the next command byte clears.
//               Build option EIGHTY_TWOS_RESP_AUTOINC_EN: keep streaming data
//               bytes with an auto-incrementing, wrapping address while ncs
//               stays low.
// Revision    : 1.0 - initial release
// ============================================================================
module eighty_twos_bus_responder
  import eighty_twos_resp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ncs,
  input  logic       strb,
  input  logic       store_en,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       done,
  output logic       err
);

  state_t          r_state;
  state_t          w_next_state;

  logic            r_is_write;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_bus_out;
  logic            r_done;
  logic            r_err;

  logic            w_byte_wr;
  logic            w_byte_rd;
  logic            w_addr_oor;
  logic            w_cmd_acc;
  logic            w_addr_acc;
  logic            w_addr_bad;
  logic            w_we;
  logic            w_load_rd;
  logic            w_done_set;
  logic            w_addr_inc;
  logic [7:0]      w_rdata;

  // Strobed byte qualified by direction: initiator-driven or acknowledge
  assign w_byte_wr  = !ncs && strb && store_en;
  assign w_byte_rd  = !ncs && strb && !store_en;

  // Compare one bit wider so DEPTH = 256 never reports out of range
  assign w_addr_oor = ({1'b0, bus_in} >= 9'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes; a high ncs always returns to IDLE
  always_comb begin
    w_next_state = r_state;
    w_cmd_acc    = 1'b0;
    w_addr_acc   = 1'b0;
    w_addr_bad   = 1'b0;
    w_we         = 1'b0;
    w_load_rd    = 1'b0;
    w_done_set   = 1'b0;
    w_addr_inc   = 1'b0;
    if (ncs) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_wr) begin
            w_cmd_acc    = 1'b1;
            w_next_state = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_byte_wr) begin
            if (w_addr_oor) begin
              w_addr_bad   = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_addr_acc   = 1'b1;
              w_next_state = r_is_write ? ST_WDATA : ST_RTURN;
            end
          end
        end
        ST_WDATA: begin
          if (w_byte_wr) begin
            w_we         = 1'b1;
            w_done_set   = 1'b1;
`ifdef EIGHTY_TWOS_RESP_AUTOINC_EN
            w_addr_inc   = 1'b1;
            w_next_state = ST_WDATA;
`else
            w_next_state = ST_IDLE;
`endif
          end
        end
        ST_RTURN: begin
          // Turnaround cycle: fetch the byte the initiator will see next
          w_load_rd    = 1'b1;
          w_next_state = ST_RDATA;
        end
        ST_RDATA: begin
          if (w_byte_rd) begin
            w_done_set   = 1'b1;
`ifdef EIGHTY_TWOS_RESP_AUTOINC_EN
            w_addr_inc   = 1'b1;
            w_next_state = ST_RTURN;
`else
            w_next_state = ST_IDLE;
`endif
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Transaction datapath: direction, address, read byte, done and err flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_bus_out  <= 8'h00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_cmd_acc) begin
        r_is_write <= bus_in[CMD_WRITE_BIT];
        r_err      <= 1'b0;
      end
      if (w_addr_bad) begin
        r_err <= 1'b1;
      end
      if (w_addr_acc) begin
        r_addr <= bus_in[AW-1:0];
      end else if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_load_rd) begin
        r_bus_out <= w_rdata;
      end
    end
  end

  eighty_twos_resp_regfile #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .nrst    (nrst),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (bus_in),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  // Drive the bus only while presenting read data and still selected
  assign bus_oe  = (r_state == ST_RDATA) && !ncs;
  assign bus_out = r_bus_out;
  assign done    = r_done;
  assign err     = r_err;

endmodule : eighty_twos_bus_responder
`default_nettype wire

// File: tb/tb_eighty_twos_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_eighty_twos_bus_responder
// Description : Self-checking bench for eighty_twos_bus_responder (DEPTH=16).
//               A vector table covers write/read, turnaround, range error,
//               ncs abort and direction filtering; short hand-written
//               sequences cover the ncs output gate, reset aborts and the
//               optional EIGHTY_TWOS_RESP_AUTOINC_EN burst mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eighty_twos_bus_responder;

  logic       clk;
  logic       nrst;
  logic       ncs;
  logic       strb;
  logic       store_en;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       done;
  logic       err;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       ncs;
    logic       strb;
    logic       se;
    logic [7:0] din;
    logic       oe;
    logic       done;
    logic       err;
    logic       chk_out;
    logic [7:0] out;
  } vec_t;

  vec_t vecs[$];

  eighty_twos_bus_responder #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .ncs      (ncs),
    .strb     (strb),
    .store_en (store_en),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, return 1 time unit after it
  task automatic drive(input logic c, input logic s, input logic se, input logic [7:0] d);
    ncs      = c;
    strb     = s;
    store_en = se;
    bus_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic c, input logic s, input logic se, input logic [7:0] d,
                     input logic oe, input logic dn, input logic er,
                     input logic co, input logic [7:0] o);
    vec_t v;
    v.ncs = c; v.strb = s; v.se = se; v.din = d;
    v.oe = oe; v.done = dn; v.err = er; v.chk_out = co; v.out = o;
    vecs.push_back(v);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 1'b1, a);
    chk({tag, "_turn_oe"}, {7'd0, bus_oe}, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk({tag, "_oe"}, {7'd0, bus_oe}, 8'h01);
    chk({tag, "_data"}, bus_out, exp);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    chk({tag, "_done"}, {7'd0, done}, 8'h01);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nrst     = 1'b0;
    ncs      = 1'b1;
    strb     = 1'b0;
    store_en = 1'b1;
    bus_in   = 8'h00;

    //   ncs  strb se   din    | oe   done err  chk  out
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); // 0 idle
    add(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 1 write cmd
    add(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 2 addr 3
    add(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 3 wrong dir, ignored
    add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); // 4 data A5
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 5
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 6 read cmd
    add(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 7 addr 3 -> turnaround
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5); // 8 first RDATA
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5); // 9 held
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5); // 10 ack
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5); // 11
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 12 read cmd
    add(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); // 13 addr 16 -> err
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); // 14 err sticky, idle
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 15 cmd clears err
    add(1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 16 addr 15
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); // 17 mem[15]=00
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00); // 18 abandon, no done
    add(1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 19 write cmd
    add(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 20 addr 3
    add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 21 ncs high + strb
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 22 no done
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 23 read cmd
    add(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 24 addr 3
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5); // 25 still A5
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5); // 26 ack
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 27
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 28 write cmd, low bits set
    add(1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 29 addr 15
    add(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); // 30 data 3C
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 31
    add(1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 32 read cmd, low bits set
    add(1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 33 addr 15
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C); // 34 new value
    add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C); // 35 wrong dir ack ignored
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C); // 36 ack
    add(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // 37

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe",   {7'd0, bus_oe}, 8'h00);
    chk("rst_out",  bus_out,        8'h00);
    chk("rst_done", {7'd0, done},   8'h00);
    chk("rst_err",  {7'd0, err},    8'h00);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ncs, vecs[i].strb, vecs[i].se, vecs[i].din);
      chk($sformatf("v%0d_oe", i),   {7'd0, bus_oe}, {7'd0, vecs[i].oe});
      chk($sformatf("v%0d_done", i), {7'd0, done},   {7'd0, vecs[i].done});
      chk($sformatf("v%0d_err", i),  {7'd0, err},    {7'd0, vecs[i].err});
      if (vecs[i].chk_out) begin
        chk($sformatf("v%0d_out", i), bus_out, vecs[i].out);
      end
    end

    // bus_oe follows ncs combinationally while in RDATA
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h03);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk("gate_oe_sel", {7'd0, bus_oe}, 8'h01);
    ncs = 1'b1;
    #1;
    chk("gate_oe_desel", {7'd0, bus_oe}, 8'h00);
    ncs = 1'b0;
    #1;
    chk("gate_oe_resel", {7'd0, bus_oe}, 8'h01);

    // Reset in RDATA: output enable drops at once, storage is cleared
    #1;
    nrst = 1'b0;
    #1;
    chk("rstmid_oe",  {7'd0, bus_oe}, 8'h00);
    chk("rstmid_out", bus_out,        8'h00);
    ncs = 1'b1;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    do_read("clr3",  8'h03, 8'h00);
    do_read("clr15", 8'h0F, 8'h00);

    // Reset while a write byte is strobed in WDATA: write must not land
    drive(1'b0, 1'b1, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 1'b1, 8'h05);
    ncs      = 1'b0;
    strb     = 1'b1;
    store_en = 1'b1;
    bus_in   = 8'h77;
    #1;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_done", {7'd0, done}, 8'h00);
    nrst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    do_read("abort5", 8'h05, 8'h00);

`ifdef EIGHTY_TWOS_RESP_AUTOINC_EN
    // Burst write wrapping from the top address to zero
    drive(1'b0, 1'b1, 1'b1, 8'h80);
    drive(1'b0, 1'b1, 1'b1, 8'h0F);
    drive(1'b0, 1'b1, 1'b1, 8'h11);
    chk("burst_done0", {7'd0, done}, 8'h01);
    drive(1'b0, 1'b1, 1'b1, 8'h22);
    chk("burst_done1", {7'd0, done}, 8'h01);
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    chk("burst_end", {7'd0, done}, 8'h00);
    do_read("burst15", 8'h0F, 8'h11);
    do_read("burst0",  8'h00, 8'h22);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_eighty_twos_bus_responder
`default_nettype wire

// File: doc/eighty_twos_bus_responder.md
EIGHTY_TWOS_BUS_RESPONDER -- requirements
Module: eighty_twos_bus_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit storage locations (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, address bits used (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port nrst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port ncs  input  1  chip select from initiator, active-low.
REQ-006 SHALL have port strb  input  1  byte strobe; one byte accepted per clk with ncs=0, strb=1.
REQ-007 SHALL have port store_en  input  1  initiator drive flag; 1 = initiator drives bus_in.
REQ-008 SHALL have port bus_in  input  8  byte from initiator.
REQ-009 SHALL have port bus_out  output  8  byte to initiator.
REQ-010 SHALL have port bus_oe  output  1  responder output enable, active-high.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completed read or write byte.
REQ-012 SHALL have port err  output  1  sticky error flag, cleared by next command byte.

Function
REQ-013 A byte SHALL be accepted only on a clk edge where ncs=0, strb=1 and store_en matches the state's required direction (1 in CMD/ADDR/WDATA, 0 in RDATA); mismatched bytes are ignored.
REQ-014 States SHALL be IDLE, ADDR, WDATA, RTURN, RDATA.
REQ-015 IDLE: accepted byte is the command; bit7=1 write, bit7=0 read; bits[6:0] ignored; -> ADDR; err cleared.
REQ-016 ADDR: accepted byte is the address; if value >= DEPTH, err=1 and -> IDLE; else latch address, -> WDATA (write) or RTURN (read).
REQ-017 WDATA: accepted byte SHALL be written to mem[addr] at that edge; done=1 the next cycle; -> IDLE.
REQ-018 RTURN: exactly one cycle, bus_oe=0 (bus turnaround); bus_out loaded with mem[addr]; -> RDATA.
REQ-019 RDATA: bus_oe=1, bus_out stable; accepted byte (initiator acknowledge) SHALL pulse done next cycle; -> IDLE.
REQ-020 bus_oe SHALL be 1 only in RDATA and only while ncs=0 (combinational gate on ncs).
REQ-021 ncs=1 on any edge SHALL force state to IDLE; simultaneous strb ignored; no memory write.
REQ-022 Write to mem[a] followed by read of mem[a] SHALL return the new value (no stale data).
REQ-023 Read latency: first RDATA cycle is 2 edges after the accepted address byte.

Reset
REQ-024 On nrst=0: state=IDLE, bus_out=8'h00, bus_oe=0, done=0, err=0, address=0, all memory locations=8'h00.
REQ-025 Reset asserted mid-transaction SHALL abort without completing any pending write.

Configuration
REQ-026 Macro EIGHTY_TWOS_RESP_AUTOINC_EN defined: after a byte in WDATA or RDATA, if ncs stays 0, state SHALL remain WDATA (or pass through RTURN back to RDATA) with address+1 wrapping DEPTH-1 -> 0; done pulses per byte.
REQ-027 Macro undefined: single-byte transactions only, per REQ-017/REQ-019.

Structure
REQ-028 Package eighty_twos_resp_pkg SHALL hold the state enum, CMD_WRITE_BIT=7 constant and default DEPTH.
REQ-029 Storage SHALL be a sub-module eighty_twos_resp_regfile (one sync write port, one async read port, async clear).

Verification
REQ-030 Write cmd 8'h80, addr 8'h03, data 8'hA5 -> done pulse; read cmd 8'h00, addr 8'h03 -> bus_oe=1 two edges later, bus_out=8'hA5.
REQ-031 Read addr 8'h10 with DEPTH=16 -> err=1, bus_oe never 1, state IDLE; next cmd byte clears err.
REQ-032 ncs deasserted in WDATA together with strb, data 8'hFF -> mem unchanged, bus_oe=0, state IDLE.
REQ-033 nrst pulsed during RDATA -> bus_oe=0 immediately, all locations read 8'h00 afterwards.
REQ-034 With EIGHTY_TWOS_RESP_AUTOINC_EN: write burst at addr 8'h0F of 8'h11,8'h22 -> mem[15]=8'h11, mem[0]=8'h22, two done pulses.
REQ-035 store_en=0 during WDATA strobe -> byte ignored, no done, state stays WDATA.
